// File: rtl/counter_run_controller.sv
// Run controller for a WIDTH-bit event counter: START/STOP/PAUSE/CLEAR over valid/ready, IDLE/LOAD/RUN/PAUSE.
// Latency: START accepted at edge N, q=start after N+1, first step at N+2+P; q/tick/done are registered.
// Backpressure: cmd_ready drops only for the single LOAD cycle; every other state accepts a command each cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready/cmd_op       command handshake (00 START, 01 STOP, 10 PAUSE toggle, 11 CLEAR)
//   cfg_limit/prescale/down/reload   run configuration, sampled only on an accepted START
//   q, tick, done                    count, per-step pulse, terminal-count pulse
//   busy                             controller is not IDLE
module counter_run_controller #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cfg_limit,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_down,
    input  logic                  cfg_reload,
    output logic [WIDTH-1:0]      q,
    output logic                  tick,
    output logic                  done,
    output logic                  busy
);

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef struct packed {
        logic [WIDTH-1:0]      limit;
        logic [PRESCALE_W-1:0] prescale;
        logic                  down;
        logic                  reload;
    } cfg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE
    } state_t;

    state_t                state, state_n;
    cfg_t                  cfg, cfg_n, cfg_in;
    logic [WIDTH-1:0]      q_n;
    logic [PRESCALE_W-1:0] pre, pre_n;
    logic                  tick_n, done_n;
    logic                  accept;
    logic [WIDTH-1:0]      start_val, term_val, q_step;

    assign cfg_in    = {cfg_limit, cfg_prescale, cfg_down, cfg_reload};
    assign cmd_ready = (state != S_LOAD);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // Up runs 0 -> limit, down runs limit -> 0; reaching the terminal reloads the start value.
    assign start_val = cfg.down ? cfg.limit : '0;
    assign term_val  = cfg.down ? '0 : cfg.limit;
    assign q_step    = (q == term_val) ? start_val
                     : (cfg.down ? q - WIDTH'(1) : q + WIDTH'(1));

    always_comb begin
        state_n = state;
        cfg_n   = cfg;
        q_n     = q;
        pre_n   = pre;
        tick_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_START) begin
                        cfg_n   = cfg_in;
                        state_n = S_LOAD;
                    end else if (cmd_op == OP_CLEAR) begin
                        q_n = '0;
                    end
                end
            end
            S_LOAD: begin
                q_n     = start_val;
                pre_n   = '0;
                state_n = S_RUN;
            end
            S_RUN, S_PAUSE: begin
                // An accepted command pre-empts any step due this cycle.
                if (accept) begin
                    case (cmd_op)
                        OP_START: begin
                            cfg_n   = cfg_in;
                            state_n = S_LOAD;
                        end
                        OP_STOP:  state_n = S_IDLE;
                        OP_PAUSE: state_n = (state == S_RUN) ? S_PAUSE : S_RUN;
                        OP_CLEAR: begin
                            q_n     = '0;
                            state_n = S_IDLE;
                        end
                        default:  state_n = state;
                    endcase
                end else if (state == S_RUN) begin
                    if (pre == cfg.prescale) begin
                        pre_n  = '0;
                        q_n    = q_step;
                        tick_n = 1'b1;
                        done_n = (q_step == term_val);
                        if ((q_step == term_val) && !cfg.reload) begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        pre_n = pre + PRESCALE_W'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cfg   <= '0;
            q     <= '0;
            pre   <= '0;
            tick  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cfg   <= cfg_n;
            q     <= q_n;
            pre   <= pre_n;
            tick  <= tick_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_counter_run_controller.sv
// Testbench for counter_run_controller: directed scenarios with spec-derived constants,
// then randomized commands/configs checked cycle by cycle against a behavioural model.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_counter_run_controller;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cfg_limit;
    logic [3:0] cfg_prescale;
    logic       cfg_down;
    logic       cfg_reload;
    logic [3:0] q;
    logic       tick;
    logic       done;
    logic       busy;

    int compares = 0;
    int fails    = 0;

    // Behavioural model: run/pause/load flags, remaining cycles until the next step.
    int m_q, m_rem, m_lim, m_p;
    bit m_tick, m_done, m_load, m_run, m_pause, m_down, m_rel;

    counter_run_controller #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cfg_limit    (cfg_limit),
        .cfg_prescale (cfg_prescale),
        .cfg_down     (cfg_down),
        .cfg_reload   (cfg_reload),
        .q            (q),
        .tick         (tick),
        .done         (done),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_q = 0; m_rem = 0; m_lim = 0; m_p = 0;
        m_tick = 0; m_done = 0; m_load = 0; m_run = 0; m_pause = 0;
        m_down = 0; m_rel = 0;
    endtask

    task automatic model_edge();
        bit acc;
        int st, tm, nxt;
        acc    = cmd_valid && !m_load;
        m_tick = 0;
        m_done = 0;
        st     = m_down ? m_lim : 0;
        tm     = m_down ? 0 : m_lim;
        if (m_load) begin
            m_q = st; m_rem = m_p; m_load = 0; m_run = 1;
        end else if (acc) begin
            case (cmd_op)
                OP_START: begin
                    m_lim = cfg_limit; m_p = cfg_prescale;
                    m_down = cfg_down; m_rel = cfg_reload;
                    m_load = 1; m_run = 0; m_pause = 0;
                end
                OP_STOP: begin m_run = 0; m_pause = 0; end
                OP_PAUSE: begin
                    if (m_run) begin m_run = 0; m_pause = 1; end
                    else if (m_pause) begin m_pause = 0; m_run = 1; end
                end
                default: begin m_q = 0; m_run = 0; m_pause = 0; end
            endcase
        end else if (m_run) begin
            if (m_rem == 0) begin
                if (m_q == tm) nxt = st;
                else nxt = m_down ? (m_q + 15) % 16 : (m_q + 1) % 16;
                m_q = nxt; m_tick = 1; m_done = (nxt == tm); m_rem = m_p;
                if (m_done && !m_rel) m_run = 0;
            end else begin
                m_rem--;
            end
        end
    endtask

    function automatic logic [7:0] exp_vec();
        return {4'(m_q), m_tick, m_done, (m_load | m_run | m_pause), !m_load};
    endfunction

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Present one command for one edge, then scramble cfg so later edges cannot rely on it.
    task automatic issue(input logic [1:0] op, input int lim, input int p, input bit dn, input bit rl);
        cmd_valid = 1'b1; cmd_op = op;
        cfg_limit = 4'(lim); cfg_prescale = 4'(p); cfg_down = dn; cfg_reload = rl;
        clk_step();
        cmd_valid = 1'b0;
        cfg_limit = 4'($urandom); cfg_prescale = 4'($urandom);
        cfg_down = 1'($urandom); cfg_reload = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        cfg_limit = 4'd0; cfg_prescale = 4'd0; cfg_down = 1'b0; cfg_reload = 1'b0;
        model_reset();
        #12;
        compares++;
        if ({q, tick, done, busy, cmd_ready} !== 8'b0000_0001) begin
            fails++;
            $display("FAIL reset_state: got %b want 00000001", {q, tick, done, busy, cmd_ready});
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_up_oneshot();
        issue(OP_START, 9, 0, 1'b0, 1'b0);
        compares++;
        if ({cmd_ready, busy} !== 2'b01) begin
            fails++; $display("FAIL up_load_ready: got rdy/busy %b want 01", {cmd_ready, busy});
        end
        clk_step();
        compares++;
        if ({q, tick, done, busy, cmd_ready} !== 8'b0000_0011) begin
            fails++; $display("FAIL up_loaded: got %b want 00000011", {q, tick, done, busy, cmd_ready});
        end
        for (int i = 1; i <= 9; i++) begin
            clk_step();
            compares++;
            if ({q, tick, done, busy} !== {4'(i), 1'b1, 1'(i == 9), 1'(i != 9)}) begin
                fails++; $display("FAIL up_step%0d: got q=%0d t=%b d=%b b=%b", i, q, tick, done, busy);
            end
        end
        clk_step();
        compares++;
        if ({q, tick, done, busy} !== {4'd9, 3'b000}) begin
            fails++; $display("FAIL up_hold: got q=%0d t=%b d=%b b=%b want 9 000", q, tick, done, busy);
        end
    endtask

    task automatic test_down_reload();
        int eq;
        bit et, ed;
        issue(OP_START, 3, 2, 1'b1, 1'b1);
        clk_step();
        compares++;
        if (q !== 4'd3) begin
            fails++; $display("FAIL down_loaded: got q=%0d want 3", q);
        end
        eq = 3;
        for (int c = 1; c <= 15; c++) begin
            clk_step();
            et = (c % 3 == 0);
            if (et) eq = (eq == 0) ? 3 : eq - 1;
            ed = et && (eq == 0);
            compares++;
            if ({q, tick, done, busy} !== {4'(eq), et, ed, 1'b1}) begin
                fails++;
                $display("FAIL down_cycle%0d: got q=%0d t=%b d=%b want q=%0d t=%b d=%b",
                         c, q, tick, done, eq, et, ed);
            end
        end
        issue(OP_CLEAR, 0, 0, 1'b0, 1'b0);
        compares++;
        if ({q, busy} !== 5'b0000_0) begin
            fails++; $display("FAIL down_clear: got q=%0d busy=%b want 0 0", q, busy);
        end
    endtask

    task automatic test_pause_resume();
        issue(OP_START, 15, 0, 1'b0, 1'b0);
        repeat (6) clk_step();
        issue(OP_PAUSE, 0, 0, 1'b0, 1'b0);
        compares++;
        if ({q, tick, busy} !== {4'd5, 1'b0, 1'b1}) begin
            fails++; $display("FAIL pause_enter: got q=%0d t=%b b=%b want 5 0 1", q, tick, busy);
        end
        for (int i = 0; i < 4; i++) begin
            clk_step();
            compares++;
            if ({q, tick, done, busy} !== {4'd5, 3'b001}) begin
                fails++; $display("FAIL pause_frozen%0d: got q=%0d t=%b b=%b", i, q, tick, busy);
            end
        end
        issue(OP_PAUSE, 0, 0, 1'b0, 1'b0);
        clk_step();
        compares++;
        if ({q, tick} !== {4'd6, 1'b1}) begin
            fails++; $display("FAIL resume_6: got q=%0d t=%b want 6 1", q, tick);
        end
        clk_step();
        compares++;
        if ({q, tick} !== {4'd7, 1'b1}) begin
            fails++; $display("FAIL resume_7: got q=%0d t=%b want 7 1", q, tick);
        end
    endtask

    task automatic test_stop_clear();
        issue(OP_STOP, 0, 0, 1'b0, 1'b0);
        compares++;
        if ({q, tick, done, busy} !== {4'd7, 3'b000}) begin
            fails++; $display("FAIL stop_hold: got q=%0d t=%b d=%b b=%b want 7 000", q, tick, done, busy);
        end
        issue(OP_STOP, 0, 0, 1'b0, 1'b0);
        issue(OP_PAUSE, 0, 0, 1'b0, 1'b0);
        clk_step();
        compares++;
        if ({q, busy, cmd_ready} !== {4'd7, 1'b0, 1'b1}) begin
            fails++; $display("FAIL idle_noop: got q=%0d b=%b r=%b want 7 0 1", q, busy, cmd_ready);
        end
        issue(OP_CLEAR, 0, 0, 1'b0, 1'b0);
        compares++;
        if ({q, busy} !== 5'b0000_0) begin
            fails++; $display("FAIL idle_clear: got q=%0d b=%b want 0 0", q, busy);
        end
    endtask

    task automatic test_cmd_vs_terminal();
        issue(OP_START, 9, 0, 1'b0, 1'b0);
        repeat (9) clk_step();
        compares++;
        if (q !== 4'd8) begin
            fails++; $display("FAIL term_pre: got q=%0d want 8", q);
        end
        issue(OP_PAUSE, 0, 0, 1'b0, 1'b0);
        compares++;
        if ({q, tick, done, busy} !== {4'd8, 3'b001}) begin
            fails++; $display("FAIL term_pause: got q=%0d t=%b d=%b b=%b want 8 001", q, tick, done, busy);
        end
        repeat (2) clk_step();
        compares++;
        if ({q, tick, done, busy} !== {4'd8, 3'b001}) begin
            fails++; $display("FAIL term_frozen: got q=%0d t=%b d=%b b=%b want 8 001", q, tick, done, busy);
        end
        issue(OP_CLEAR, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        int ndone;
        issue(OP_START, 9, 3, 1'b0, 1'b1);
        repeat (6) clk_step();
        #3 rst = 1'b0;
        #1;
        compares++;
        if ({q, tick, done, busy, cmd_ready} !== 8'b0000_0001) begin
            fails++; $display("FAIL async_reset: got %b want 00000001", {q, tick, done, busy, cmd_ready});
        end
        @(posedge clk); #1;
        compares++;
        if ({q, busy} !== 5'b0000_0) begin
            fails++; $display("FAIL reset_held: got q=%0d b=%b want 0 0", q, busy);
        end
        rst = 1'b1;
        model_reset();
        issue(OP_START, 0, 1, 1'b0, 1'b0);
        compares++;
        if (cmd_ready !== 1'b0) begin
            fails++; $display("FAIL zero_load_ready: got %b want 0", cmd_ready);
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            clk_step();
            if (done === 1'b1) ndone++;
            if (i == 2) begin
                compares++;
                if ({q, tick, done, busy} !== {4'd0, 3'b110}) begin
                    fails++; $display("FAIL zero_step: got q=%0d t=%b d=%b b=%b want 0 110", q, tick, done, busy);
                end
            end
        end
        compares++;
        if (ndone !== 1) begin
            fails++; $display("FAIL zero_done_count: got %0d want 1", ndone);
        end
    endtask

    task automatic test_random();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            cmd_valid    = ($urandom_range(0, 9) == 0);
            cmd_op       = 2'($urandom);
            cfg_limit    = 4'($urandom);
            cfg_prescale = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 2));
            cfg_down     = 1'($urandom);
            cfg_reload   = 1'($urandom);
            if (i == 1500) begin
                #3 rst = 1'b0;
                #2 model_reset();
                @(posedge clk); #1;
                rst = 1'b1;
            end
            clk_step();
            compares++;
            if ({q, tick, done, busy, cmd_ready} !== exp_vec()) begin
                fails++;
                $display("FAIL random_cycle%0d: got %b want %b", i, {q, tick, done, busy, cmd_ready}, exp_vec());
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_oneshot();
        test_down_reload();
        test_pause_resume();
        test_stop_clear();
        test_cmd_vs_terminal();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
